// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache with one-word lines.
// Load hits return in the same cycle. Load misses and every store stall the core
// while a single req/ack transaction runs on the memory bus.
module dcache_wt #(
    parameter int unsigned LINES = 16
) (
    input  logic        I_clk,
    input  logic        I_rst,
    input  logic [31:0] I_addr,
    input  logic [31:0] I_wdata,
    input  logic [3:0]  I_wmask,
    input  logic        I_rd,
    input  logic        I_we,
    input  logic        I_inv,
    output logic [31:0] O_rdata,
    output logic        O_stall,
    output logic        O_mem_req,
    output logic        O_mem_we,
    output logic [31:0] O_mem_addr,
    output logic [31:0] O_mem_wdata,
    output logic [3:0]  O_mem_wmask,
    input  logic        I_mem_ack,
    input  logic [31:0] I_mem_rdata
);

    localparam int unsigned IDX  = $clog2(LINES);
    localparam int unsigned TAGW = 32 - IDX - 2;

    typedef enum logic [2:0] {
        StIdle,
        StRmiss,
        StResp,
        StWrite,
        StWdone
    } state_t;

    state_t state;

    logic [LINES-1:0] valid;
    logic [TAGW-1:0]  tags [LINES];
    logic [31:0]      data [LINES];
    logic             inv_pend;

    // Core-side lookup
    logic [IDX-1:0]  idx;
    logic [TAGW-1:0] tag;
    logic            hit;

    assign idx     = I_addr[IDX+1:2];
    assign tag     = I_addr[31:IDX+2];
    assign hit     = valid[idx] && (tags[idx] == tag);
    assign O_rdata = data[idx];

    // Bus-side lookup; the registered bus address doubles as the latched request address
    logic [IDX-1:0]  bidx;
    logic [TAGW-1:0] btag;
    logic            bhit;

    assign bidx = O_mem_addr[IDX+1:2];
    assign btag = O_mem_addr[31:IDX+2];
    assign bhit = valid[bidx] && (tags[bidx] == btag);

    // Store lane placement: shift the mask and rotate the data to the byte offset
    logic [1:0]  shamt;
    logic [3:0]  place_mask;
    logic [31:0] place_data;

    // Lane-place the lane-0 justified store; bytes past lane 3 fall off
    always_comb begin
        shamt      = I_addr[1:0];
        place_mask = I_wmask << shamt;
        case (shamt)
            2'd1:    place_data = {I_wdata[23:0], I_wdata[31:24]};
            2'd2:    place_data = {I_wdata[15:0], I_wdata[31:16]};
            2'd3:    place_data = {I_wdata[7:0],  I_wdata[31:8]};
            default: place_data = I_wdata;
        endcase
    end

    // Stall the core for misses and stores; release for the single RESP/WDONE cycle
    always_comb begin
        case (state)
            StIdle:           O_stall = (I_rd && !hit) || I_we;
            StRmiss, StWrite: O_stall = 1'b1;
            default:          O_stall = 1'b0;
        endcase
    end

    // Controller FSM with registered bus outputs, valid bits and deferred invalidate
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state       <= StIdle;
            valid       <= '0;
            inv_pend    <= 1'b0;
            O_mem_req   <= 1'b0;
            O_mem_we    <= 1'b0;
            O_mem_addr  <= '0;
            O_mem_wdata <= '0;
            O_mem_wmask <= '0;
        end else begin
            // Invalidate arriving mid-transaction is remembered until back in IDLE
            if (state != StIdle && I_inv) begin
                inv_pend <= 1'b1;
            end
            case (state)
                StIdle: begin
                    if (I_inv || inv_pend) begin
                        valid    <= '0;
                        inv_pend <= 1'b0;
                    end
                    if (I_we) begin
                        O_mem_req   <= 1'b1;
                        O_mem_we    <= 1'b1;
                        O_mem_addr  <= {I_addr[31:2], 2'b00};
                        O_mem_wdata <= place_data;
                        O_mem_wmask <= place_mask;
                        state       <= StWrite;
                    end else if (I_rd && !hit) begin
                        O_mem_req   <= 1'b1;
                        O_mem_we    <= 1'b0;
                        O_mem_addr  <= {I_addr[31:2], 2'b00};
                        O_mem_wmask <= 4'b1111;
                        state       <= StRmiss;
                    end
                end
                StRmiss: begin
                    if (I_mem_ack) begin
                        valid[bidx] <= 1'b1;
                        O_mem_req   <= 1'b0;
                        state       <= StResp;
                    end
                end
                StWrite: begin
                    if (I_mem_ack) begin
                        O_mem_req <= 1'b0;
                        state     <= StWdone;
                    end
                end
                StResp:  state <= StIdle;
                StWdone: state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

    // Tag/data arrays: fill on read ack, byte-merge on write ack only when the line hits
    always_ff @(posedge I_clk) begin
        if (!I_rst && I_mem_ack) begin
            if (state == StRmiss) begin
                data[bidx] <= I_mem_rdata;
                tags[bidx] <= btag;
            end else if (state == StWrite && bhit) begin
                for (int b = 0; b < 4; b++) begin
                    if (O_mem_wmask[b]) begin
                        data[bidx][8*b +: 8] <= O_mem_wdata[8*b +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_dcache_wt.sv
// Bench for dcache_wt: directed vector table, reset-mid-miss sequence, then
// randomized operations checked against a line-level cache model and a memory model.
module tb_dcache_wt;

    localparam int unsigned LINES = 16;
    localparam int unsigned IDX   = 4;

    localparam int OpLd    = 0;
    localparam int OpSt    = 1;
    localparam int OpInv   = 2;
    localparam int OpLdInv = 3;

    logic        I_clk = 1'b0;
    logic        I_rst;
    logic [31:0] I_addr;
    logic [31:0] I_wdata;
    logic [3:0]  I_wmask;
    logic        I_rd;
    logic        I_we;
    logic        I_inv;
    logic [31:0] O_rdata;
    logic        O_stall;
    logic        O_mem_req;
    logic        O_mem_we;
    logic [31:0] O_mem_addr;
    logic [31:0] O_mem_wdata;
    logic [3:0]  O_mem_wmask;
    logic        I_mem_ack;
    logic [31:0] I_mem_rdata;

    int n_cmp  = 0;
    int n_fail = 0;

    dcache_wt #(.LINES(LINES)) dut (
        .I_clk       (I_clk),
        .I_rst       (I_rst),
        .I_addr      (I_addr),
        .I_wdata     (I_wdata),
        .I_wmask     (I_wmask),
        .I_rd        (I_rd),
        .I_we        (I_we),
        .I_inv       (I_inv),
        .O_rdata     (O_rdata),
        .O_stall     (O_stall),
        .O_mem_req   (O_mem_req),
        .O_mem_we    (O_mem_we),
        .O_mem_addr  (O_mem_addr),
        .O_mem_wdata (O_mem_wdata),
        .O_mem_wmask (O_mem_wmask),
        .I_mem_ack   (I_mem_ack),
        .I_mem_rdata (I_mem_rdata)
    );

    always #5 I_clk = ~I_clk;

    // Backing memory: written words stored, everything else a fixed hash of the address
    logic [31:0] mem [logic [29:0]];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        logic [29:0] w;
        w = a[31:2];
        if (mem.exists(w)) return mem[w];
        return ({w, 2'b01} * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    function automatic void mem_wr(input logic [31:0] a, input logic [31:0] d,
                                   input logic [3:0] m);
        logic [31:0] w;
        w = mem_rd(a);
        for (int b = 0; b < 4; b++) if (m[b]) w[8*b +: 8] = d[8*b +: 8];
        mem[a[31:2]] = w;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    // Drive one core request and act as the bus slave, acking on the lat-th request cycle
    task automatic run_op(input int op, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wmask, input int lat, input bit mid_inv,
                          output int stalls, output logic [31:0] rdata, output logic bwe,
                          output logic [31:0] baddr, output logic [31:0] bwdata,
                          output logic [3:0] bmask, output bit timeout);
        int  reqcnt;
        bit  done;
        reqcnt  = 0;
        done    = 1'b0;
        stalls  = 0;
        timeout = 1'b0;
        rdata   = 'x;
        bwe     = 'x;
        baddr   = 'x;
        bwdata  = 'x;
        bmask   = 'x;
        @(negedge I_clk);
        I_addr  = addr;
        I_wdata = wdata;
        I_wmask = wmask;
        I_rd    = (op == OpLd || op == OpLdInv);
        I_we    = (op == OpSt);
        I_inv   = (op == OpInv || op == OpLdInv);
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            if (cyc > 0) begin
                @(negedge I_clk);
                I_inv = mid_inv && (cyc == 1);
            end
            I_mem_ack   = 1'b0;
            I_mem_rdata = $urandom;
            if (O_mem_req) begin
                reqcnt++;
                if (reqcnt == lat) begin
                    I_mem_ack   = 1'b1;
                    I_mem_rdata = mem_rd(O_mem_addr);
                    bwe         = O_mem_we;
                    baddr       = O_mem_addr;
                    bwdata      = O_mem_wdata;
                    bmask       = O_mem_wmask;
                    if (O_mem_we) mem_wr(O_mem_addr, O_mem_wdata, O_mem_wmask);
                end
            end
            #1;
            if (!O_stall) begin
                rdata = O_rdata;
                done  = 1'b1;
            end else begin
                stalls++;
            end
        end
        timeout = !done;
        @(posedge I_clk);
        #1;
        I_rd      = 1'b0;
        I_we      = 1'b0;
        I_inv     = 1'b0;
        I_mem_ack = 1'b0;
    endtask

    // Line-level reference model
    bit          mv [LINES];
    logic [31:0] mt [LINES];
    logic [31:0] md [LINES];
    bit          mpend;

    task automatic model_reset();
        for (int k = 0; k < LINES; k++) mv[k] = 1'b0;
        mpend = 1'b0;
    endtask

    task automatic do_checked(input int op, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] wmask, input int lat, input bit mid_inv,
                              input string nm);
        int unsigned ix;
        logic [31:0] tg, exp_rd, pdata, rd, ba, bwd;
        logic [7:0]  m8;
        logic [3:0]  pmask, bm;
        logic [63:0] dbl;
        logic        bwe;
        bit          hit, to;
        int          s, exp_stall, stalls;
        ix     = (addr >> 2) % LINES;
        tg     = addr >> (2 + IDX);
        s      = int'(addr[1:0]);
        m8     = {4'b0000, wmask} << s;
        pmask  = m8[3:0];
        dbl    = {wdata, wdata} << (8 * s);
        pdata  = dbl[63:32];
        exp_rd = 'x;
        hit    = mv[ix] && (mt[ix] == tg);
        if (op == OpInv || op == OpLdInv || mpend) begin
            model_reset();
        end
        case (op)
            OpLd, OpLdInv: begin
                exp_stall = hit ? 0 : 1 + lat;
                exp_rd    = hit ? md[ix] : mem_rd(addr);
                if (!hit) begin
                    mv[ix] = 1'b1;
                    mt[ix] = tg;
                    md[ix] = exp_rd;
                end
            end
            OpSt: begin
                exp_stall = 1 + lat;
                if (mv[ix] && mt[ix] == tg)
                    for (int b = 0; b < 4; b++) if (pmask[b]) md[ix][8*b +: 8] = pdata[8*b +: 8];
            end
            default: exp_stall = 0;
        endcase
        if (mid_inv && exp_stall > 0) mpend = 1'b1;

        run_op(op, addr, wdata, wmask, lat, mid_inv, stalls, rd, bwe, ba, bwd, bm, to);
        check({nm, " done"}, 32'(to), 32'd0);
        check({nm, " stall"}, 32'(stalls), 32'(exp_stall));
        if (op == OpLd || op == OpLdInv) check({nm, " rdata"}, rd, exp_rd);
        if (exp_stall > 0) begin
            check({nm, " bus addr"}, ba, {addr[31:2], 2'b00});
            check({nm, " bus we"}, 32'(bwe), 32'(op == OpSt));
            check({nm, " bus mask"}, 32'(bm), (op == OpSt) ? 32'(pmask) : 32'hF);
            if (op == OpSt) check({nm, " bus wdata"}, bwd, pdata);
        end
    endtask

    typedef struct {
        int          op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        int          lat;
        int          exp_stall;
        logic [31:0] exp_rdata;
        logic [31:0] exp_baddr;
        logic [31:0] exp_bwdata;
        logic [3:0]  exp_bmask;
    } vec_t;

    vec_t vecs [14];

    initial begin
        int          stalls;
        logic [31:0] rd, ba, bwd;
        logic [3:0]  bm;
        logic        bwe;
        bit          to;
        int          op, lat;
        logic [31:0] a;
        logic [3:0]  wm;

        vecs[0]  = '{OpLd,    32'h100, 32'h0,        4'h0, 3, 4, 32'hDEADBEEF, 32'h100, 32'h0,        4'hF};
        vecs[1]  = '{OpLd,    32'h100, 32'h0,        4'h0, 1, 0, 32'hDEADBEEF, 32'h0,   32'h0,        4'h0};
        vecs[2]  = '{OpSt,    32'h102, 32'h000000AA, 4'h1, 2, 3, 32'h0,        32'h100, 32'h00AA0000, 4'h4};
        vecs[3]  = '{OpLd,    32'h100, 32'h0,        4'h0, 1, 0, 32'hDEAABEEF, 32'h0,   32'h0,        4'h0};
        vecs[4]  = '{OpSt,    32'h200, 32'h12345678, 4'hF, 1, 2, 32'h0,        32'h200, 32'h12345678, 4'hF};
        vecs[5]  = '{OpLd,    32'h200, 32'h0,        4'h0, 1, 2, 32'h12345678, 32'h200, 32'h0,        4'hF};
        vecs[6]  = '{OpLd,    32'h140, 32'h0,        4'h0, 1, 2, 32'h11112222, 32'h140, 32'h0,        4'hF};
        vecs[7]  = '{OpLd,    32'h100, 32'h0,        4'h0, 1, 2, 32'hDEAABEEF, 32'h100, 32'h0,        4'hF};
        vecs[8]  = '{OpInv,   32'h0,   32'h0,        4'h0, 1, 0, 32'h0,        32'h0,   32'h0,        4'h0};
        vecs[9]  = '{OpLd,    32'h100, 32'h0,        4'h0, 2, 3, 32'hDEAABEEF, 32'h100, 32'h0,        4'hF};
        vecs[10] = '{OpSt,    32'h003, 32'h0000BBCC, 4'h3, 1, 2, 32'h0,        32'h000, 32'hCC0000BB, 4'h8};
        vecs[11] = '{OpLd,    32'h000, 32'h0,        4'h0, 1, 2, 32'hCC020304, 32'h000, 32'h0,        4'hF};
        vecs[12] = '{OpLdInv, 32'h000, 32'h0,        4'h0, 1, 0, 32'hCC020304, 32'h0,   32'h0,        4'h0};
        vecs[13] = '{OpLd,    32'h000, 32'h0,        4'h0, 1, 2, 32'hCC020304, 32'h000, 32'h0,        4'hF};

        mem[30'h40] = 32'hDEADBEEF;
        mem[30'h50] = 32'h11112222;
        mem[30'h00] = 32'h01020304;

        I_rst = 1'b1; I_addr = '0; I_wdata = '0; I_wmask = '0;
        I_rd = 1'b0; I_we = 1'b0; I_inv = 1'b0; I_mem_ack = 1'b0; I_mem_rdata = '0;
        repeat (3) @(posedge I_clk);
        #1 I_rst = 1'b0;
        @(negedge I_clk);
        check("reset req",   32'(O_mem_req),   32'd0);
        check("reset we",    32'(O_mem_we),    32'd0);
        check("reset addr",  O_mem_addr,       32'd0);
        check("reset wdata", O_mem_wdata,      32'd0);
        check("reset wmask", 32'(O_mem_wmask), 32'd0);
        check("reset stall", 32'(O_stall),     32'd0);

        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].wmask, vecs[i].lat, 1'b0,
                   stalls, rd, bwe, ba, bwd, bm, to);
            check($sformatf("vec%0d done", i), 32'(to), 32'd0);
            check($sformatf("vec%0d stall", i), 32'(stalls), 32'(vecs[i].exp_stall));
            if (vecs[i].op == OpLd || vecs[i].op == OpLdInv)
                check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
            if (vecs[i].exp_stall > 0) begin
                check($sformatf("vec%0d bus addr", i), ba, vecs[i].exp_baddr);
                check($sformatf("vec%0d bus we", i), 32'(bwe), 32'(vecs[i].op == OpSt));
                check($sformatf("vec%0d bus mask", i), 32'(bm), 32'(vecs[i].exp_bmask));
                if (vecs[i].op == OpSt)
                    check($sformatf("vec%0d bus wdata", i), bwd, vecs[i].exp_bwdata);
            end
        end

        // Reset during a read miss, followed by a stray ack in IDLE
        @(negedge I_clk);
        I_addr = 32'h300; I_rd = 1'b1;
        @(negedge I_clk);
        #1 check("rstseq req up", 32'(O_mem_req), 32'd1);
        I_rst = 1'b1;
        @(negedge I_clk);
        #1 check("rstseq req dropped", 32'(O_mem_req), 32'd0);
        I_rst = 1'b0; I_rd = 1'b0;
        I_mem_ack = 1'b1; I_mem_rdata = 32'hBAD0BAD0;
        @(negedge I_clk);
        #1 check("rstseq stray ack req", 32'(O_mem_req), 32'd0);
        check("rstseq stray ack stall", 32'(O_stall), 32'd0);
        I_mem_ack = 1'b0;
        model_reset();
        do_checked(OpLd, 32'h300, 32'h0, 4'h0, 1, 1'b0, "rstseq reload");

        // Randomized traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            int r;
            r  = int'($urandom_range(0, 99));
            op = (r < 45) ? OpLd : (r < 82) ? OpSt : (r < 91) ? OpInv : OpLdInv;
            a  = 32'h1000 + ($urandom_range(0, 2) << 6) + ($urandom_range(0, 7) << 2)
                 + $urandom_range(0, 3);
            case ($urandom_range(0, 2))
                0:       wm = 4'h1;
                1:       wm = 4'h3;
                default: wm = 4'hF;
            endcase
            lat = int'($urandom_range(1, 4));
            do_checked(op, a, $urandom, wm, lat, ($urandom_range(0, 9) == 0),
                       $sformatf("rand%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dcache_wt.md
Name: dcache_wt

Overview:
- Direct-mapped, write-through, no-write-allocate data cache between the core's data-memory port and the external memory bus.
- Load hits return the aligned word in the same cycle. Misses and all stores stall the core through O_stall while a req/ack transaction runs on the bus.
- The core performs unaligned load byte rotation. This block performs store lane placement.

Parameters:
- LINES, 16, number of one-word lines; power of 2, at least 2. IDX = log2(LINES).

Ports:
- I_clk  in  1  clock
- I_rst  in  1  reset, synchronous, active-high
- I_addr  in  32  core byte address
- I_wdata  in  32  core store data, lane-0 justified
- I_wmask  in  4  core byte mask, lane-0 justified (0001 SB, 0011 SH, 1111 SW)
- I_rd  in  1  load request
- I_we  in  1  store request
- I_inv  in  1  invalidate all lines
- O_rdata  out  32  aligned word at {I_addr[31:2],00}
- O_stall  out  1  core must hold its request
- O_mem_req  out  1  bus request, registered
- O_mem_we  out  1  bus write, registered
- O_mem_addr  out  32  word-aligned bus address, registered
- O_mem_wdata  out  32  lane-placed write data, registered
- O_mem_wmask  out  4  lane-placed byte mask, registered
- I_mem_ack  in  1  one-cycle acceptance; read data valid in the same cycle
- I_mem_rdata  in  32  bus read data

Behaviour:
- Address split: index = I_addr[IDX+1:2]; tag = I_addr[31:IDX+2]. Arrays: valid[LINES], tag, and data. Reads are asynchronous; writes are on the clock edge.
- hit = valid[index] && tag match. O_rdata = data[index] (combinational).
- Lane placement, with s = I_addr[1:0]:
  - mask = (I_wmask << s) truncated to 4 bits.
  - wdata = I_wdata rotated left by 8*s.
  - Bytes pushed past lane 3 are dropped; no split access.
- Reset (I_rst):
  - State goes to IDLE; all valid bits clear in one cycle.
  - O_mem_req=0, O_mem_we=0, O_mem_addr=0, O_mem_wdata=0, O_mem_wmask=0.
  - Reset mid-transaction drops req at once; a later stray ack is ignored.
- O_stall (combinational):
  - IDLE: (I_rd && !hit) || I_we.
  - RMISS and WRITE: 1.
  - RESP and WDONE: 0.
- IDLE:
  - I_we (takes priority over I_rd): latch addr, placed wdata and placed mask. Next cycle O_mem_req=1, O_mem_we=1. Go to WRITE.
  - I_rd with miss: latch addr. Next cycle O_mem_req=1, O_mem_we=0, O_mem_wmask=1111. Go to RMISS.
  - I_rd with hit: no state change; zero-wait.
  - Neither request: idle.
- RMISS:
  - Hold all bus outputs until I_mem_ack.
  - On ack: data[idx] <= I_mem_rdata, tag written, valid set, O_mem_req <= 0. Go to RESP.
- RESP: the line now hits; O_rdata holds the filled word and O_stall=0 for exactly one cycle. Go to IDLE.
- WRITE:
  - Hold bus outputs until ack.
  - On ack: if the latched address hits, merge the masked bytes into data[idx]; if it misses, the cache is unchanged. O_mem_req <= 0. Go to WDONE.
- WDONE: O_stall=0 for one cycle. Go to IDLE.
- Latency:
  - Load hit: 0 stall cycles.
  - Load miss: 1 + (cycles until ack) stall cycles, then RESP.
  - Store: same shape as a load miss.
- I_inv:
  - Clears all valid bits at the edge; honoured only in IDLE. In other states it is deferred (held pending) until IDLE.
  - I_inv together with a load in IDLE: the hit check uses pre-clear valid bits; the invalidate still applies.
- I_mem_ack outside RMISS and WRITE is ignored. O_mem_req never drops before ack.
- LINES wrap: addresses differing only above the index bits alias and evict each other.

Test Plan:
- Reset, then load 0x100 with the bus acking after 3 cycles with 0xDEADBEEF → O_stall high for 4 cycles. The RESP cycle shows O_rdata=0xDEADBEEF. A repeat load of 0x100 has zero stall and the same data.
- After that fill, SB at 0x102 with I_wdata=0x000000AA → bus write addr 0x100, mask 0100, wdata 0x00AA0000. After ack, load 0x100 returns 0xDEAABEEF.
- SW to uncached 0x200 with immediate ack → bus write seen and stall lasts 2 cycles. A following load of 0x200 misses, proving no-write-allocate.
- With LINES=16, load 0x100 then load 0x140 (same index) → each misses. A subsequent 0x100 misses again.
- Pulse I_inv after 0x100 is cached → the next 0x100 load misses. Asserting I_rst during RMISS drops O_mem_req the next cycle, and a late ack causes no array write.
- SH at 0x003 with mask 0011 → placed mask 1000 and data byte 0 moved to lane 3; the upper byte is dropped.
